// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front end: next-PC source encodings,
// sequencer states and the default reset/exception vectors.
package mips_pkg;

  typedef enum logic [1:0] {
    PCSRC_SEQ  = 2'b00,
    PCSRC_BR   = 2'b01,
    PCSRC_ERET = 2'b10,
    PCSRC_EXC  = 2'b11
  } pcsrc_e;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DELAY = 1'b1
  } seq_state_e;

  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VECTOR   = 32'h0000_0180;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational next-PC target generation: sequential, branch, jump and
// jump-register targets plus the redirect condition.
module pc_target_calc #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] pc,
  input  logic [25:0]      imm,
  input  logic [WIDTH-1:0] rs,
  input  logic             jump,
  input  logic             jr,
  input  logic             beq,
  input  logic             bne,
  input  logic             zerof,
  output logic [WIDTH-1:0] seq_target,
  output logic [WIDTH-1:0] branch_target,
  output logic [WIDTH-1:0] jump_target,
  output logic [WIDTH-1:0] jr_target,
  output logic             redirect
);

  assign seq_target    = pc + WIDTH'(4);
  assign branch_target = seq_target + {{(WIDTH-18){imm[15]}}, imm[15:0], 2'b00};
  assign jump_target   = {seq_target[WIDTH-1:28], imm, 2'b00};
  assign jr_target     = rs;
  assign redirect      = jump | jr | (beq & zerof) | (bne & ~zerof);

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: owns the PC, EPC/EXL exception context, the
// stall-latched pending exception and the optional branch-delay slot.
module pc_sequencer
  import mips_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEF_RESET_VECTOR),
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(DEF_EXC_VECTOR),
  parameter bit               DELAY_SLOT   = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_stall,
  input  logic [25:0]      i_imm,
  input  logic             i_jump,
  input  logic             i_jr,
  input  logic [WIDTH-1:0] i_rs,
  input  logic             i_beq,
  input  logic             i_bne,
  input  logic             i_zerof,
  input  logic             i_eret,
  input  logic             i_exception,
  output logic [WIDTH-1:0] o_pc,
  output logic [WIDTH-1:0] o_pc_plus4,
  output logic [WIDTH-1:0] o_epc,
  output logic             o_exl,
  output logic             o_bd,
  output logic [1:0]       o_pcsrc,
  output logic             o_exc_pending
);

  logic [WIDTH-1:0] pc_q, pc_d, epc_q, epc_d, tgt_q, tgt_d;
  logic             exl_q, exl_d, bd_q, bd_d, pend_q, pend_d;
  seq_state_e       state_q, state_d;
  pcsrc_e           pcsrc;

  logic [WIDTH-1:0] seq_target, branch_target, jump_target, jr_target, redirect_target;
  logic             redirect;

  pc_target_calc #(.WIDTH(WIDTH)) u_target (
    .pc            (pc_q),
    .imm           (i_imm),
    .rs            (i_rs),
    .jump          (i_jump),
    .jr            (i_jr),
    .beq           (i_beq),
    .bne           (i_bne),
    .zerof         (i_zerof),
    .seq_target    (seq_target),
    .branch_target (branch_target),
    .jump_target   (jump_target),
    .jr_target     (jr_target),
    .redirect      (redirect)
  );

  // When several redirect kinds are asserted together, JR wins over J over branch.
  assign redirect_target = i_jr ? jr_target : (i_jump ? jump_target : branch_target);

  always_comb begin
    // NOTE: every signal gets a default first so no path through the
    // if/else chain leaves it unassigned, which would infer a latch.
    pc_d    = pc_q;
    epc_d   = epc_q;
    exl_d   = exl_q;
    bd_d    = bd_q;
    pend_d  = pend_q;
    tgt_d   = tgt_q;
    state_d = state_q;
    pcsrc   = PCSRC_SEQ;

    if (i_stall) begin
      if (i_exception) pend_d = 1'b1;
    end else if (i_exception || pend_q) begin
      pcsrc   = PCSRC_EXC;
      pc_d    = EXC_VECTOR;
      exl_d   = 1'b1;
      pend_d  = 1'b0;
      state_d = ST_RUN;
      // In the slot the faulting context is the branch one word back.
      if (!exl_q) begin
        epc_d = (state_q == ST_DELAY) ? pc_q - WIDTH'(4) : pc_q;
        bd_d  = (state_q == ST_DELAY);
      end
    end else if (state_q == ST_DELAY) begin
      pcsrc   = PCSRC_BR;
      pc_d    = tgt_q;
      state_d = ST_RUN;
    end else if (i_eret) begin
      pcsrc = PCSRC_ERET;
      pc_d  = epc_q;
      exl_d = 1'b0;
    end else if (redirect) begin
      // o_pcsrc reports where the PC comes from: the slot instruction is sequential.
      if (DELAY_SLOT) begin
        tgt_d   = redirect_target;
        pc_d    = seq_target;
        state_d = ST_DELAY;
      end else begin
        pcsrc = PCSRC_BR;
        pc_d  = redirect_target;
      end
    end else begin
      pc_d = seq_target;
    end
  end

  always_ff @(posedge i_clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (i_rst) begin
      pc_q    <= RESET_VECTOR;
      epc_q   <= '0;
      exl_q   <= 1'b0;
      bd_q    <= 1'b0;
      pend_q  <= 1'b0;
      tgt_q   <= '0;
      state_q <= ST_RUN;
    end else begin
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      exl_q   <= exl_d;
      bd_q    <= bd_d;
      pend_q  <= pend_d;
      tgt_q   <= tgt_d;
      state_q <= state_d;
    end
  end

  assign o_pc          = pc_q;
  assign o_pc_plus4    = seq_target;
  assign o_epc         = epc_q;
  assign o_exl         = exl_q;
  assign o_bd          = bd_q;
  assign o_pcsrc       = pcsrc;
  assign o_exc_pending = pend_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: one instance without and one with the delay slot,
// shared stimulus, a behavioural model per instance and directed anchors.
module tb_pc_sequencer;

  localparam logic [31:0] RST_VEC = 32'h0000_0000;
  localparam logic [31:0] EXC_VEC = 32'h0000_0180;

  logic        clk = 1'b0;
  logic        rst, stall, jump, jr, beq, bne, zerof, eret, exception;
  logic [25:0] imm;
  logic [31:0] rs;

  logic [31:0] pc_o[2], pc4_o[2], epc_o[2];
  logic        exl_o[2], bd_o[2], pend_o[2];
  logic [1:0]  pcsrc_o[2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pc_sequencer #(.WIDTH(32), .RESET_VECTOR(RST_VEC), .EXC_VECTOR(EXC_VEC), .DELAY_SLOT(1'b0)) u0 (
    .i_clk(clk), .i_rst(rst), .i_stall(stall), .i_imm(imm), .i_jump(jump), .i_jr(jr),
    .i_rs(rs), .i_beq(beq), .i_bne(bne), .i_zerof(zerof), .i_eret(eret),
    .i_exception(exception), .o_pc(pc_o[0]), .o_pc_plus4(pc4_o[0]), .o_epc(epc_o[0]),
    .o_exl(exl_o[0]), .o_bd(bd_o[0]), .o_pcsrc(pcsrc_o[0]), .o_exc_pending(pend_o[0])
  );

  pc_sequencer #(.WIDTH(32), .RESET_VECTOR(RST_VEC), .EXC_VECTOR(EXC_VEC), .DELAY_SLOT(1'b1)) u1 (
    .i_clk(clk), .i_rst(rst), .i_stall(stall), .i_imm(imm), .i_jump(jump), .i_jr(jr),
    .i_rs(rs), .i_beq(beq), .i_bne(bne), .i_zerof(zerof), .i_eret(eret),
    .i_exception(exception), .o_pc(pc_o[1]), .o_pc_plus4(pc4_o[1]), .o_epc(epc_o[1]),
    .o_exl(exl_o[1]), .o_bd(bd_o[1]), .o_pcsrc(pcsrc_o[1]), .o_exc_pending(pend_o[1])
  );

  // Architectural view of each sequencer; slot=1 means the next fetch is the stored target.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] epc;
    logic [31:0] tgt;
    logic        exl;
    logic        bd;
    logic        pend;
    logic        slot;
  } mstate_t;

  mstate_t m[2];
  bit      m_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit redirect_now();
    return jump | jr | (beq & zerof) | (bne & ~zerof);
  endfunction

  function automatic logic [31:0] model_target(input logic [31:0] pc);
    logic [31:0] link = pc + 32'd4;
    int          off  = int'($signed(imm[15:0])) * 4;
    if (jr) return rs;
    if (jump) return (link & 32'hF000_0000) | (32'(imm) << 2);
    return link + 32'(off);
  endfunction

  function automatic logic [1:0] model_pcsrc(input int k);
    if (stall) return 2'b00;
    if (exception || m[k].pend) return 2'b11;
    if (m[k].slot) return 2'b01;
    if (eret) return 2'b10;
    if (redirect_now()) return (k == 1) ? 2'b00 : 2'b01;
    return 2'b00;
  endfunction

  task automatic model_step(input int k);
    mstate_t s = m[k];
    if (rst) begin
      s    = '0;
      s.pc = RST_VEC;
    end else if (stall) begin
      if (exception) s.pend = 1'b1;
    end else if (exception || s.pend) begin
      if (!s.exl) begin
        s.epc = s.slot ? s.pc - 32'd4 : s.pc;
        s.bd  = s.slot;
      end
      s.exl  = 1'b1;
      s.pend = 1'b0;
      s.slot = 1'b0;
      s.pc   = EXC_VEC;
    end else if (s.slot) begin
      s.pc   = s.tgt;
      s.slot = 1'b0;
    end else if (eret) begin
      s.pc  = s.epc;
      s.exl = 1'b0;
    end else if (redirect_now() && k == 1) begin
      s.tgt  = model_target(s.pc);
      s.slot = 1'b1;
      s.pc   = s.pc + 32'd4;
    end else if (redirect_now()) begin
      s.pc = model_target(s.pc);
    end else begin
      s.pc = s.pc + 32'd4;
    end
    m[k] = s;
  endtask

  always @(posedge clk) begin
    if (rst) m_valid = 1'b1;
    model_step(0);
    model_step(1);
  end

  always @(negedge clk) begin
    if (m_valid) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("u%0d pc", k),      pc_o[k],            m[k].pc);
        check($sformatf("u%0d pc_plus4", k), pc4_o[k],          m[k].pc + 32'd4);
        check($sformatf("u%0d epc", k),     epc_o[k],           m[k].epc);
        check($sformatf("u%0d exl", k),     32'(exl_o[k]),      32'(m[k].exl));
        check($sformatf("u%0d bd", k),      32'(bd_o[k]),       32'(m[k].bd));
        check($sformatf("u%0d pending", k), 32'(pend_o[k]),     32'(m[k].pend));
        check($sformatf("u%0d pcsrc", k),   32'(pcsrc_o[k]),    32'(model_pcsrc(k)));
      end
    end
  end

  task automatic idle();
    rst = 1'b0; stall = 1'b0; jump = 1'b0; jr = 1'b0; beq = 1'b0; bne = 1'b0;
    zerof = 1'b0; eret = 1'b0; exception = 1'b0; imm = '0; rs = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Literal anchor applied to both the DUT and the model.
  task automatic expect_lit(input int k, input string name, input logic [31:0] act,
                            input logic [31:0] mdl, input logic [31:0] lit);
    check($sformatf("u%0d %s", k, name), act, lit);
    check($sformatf("model%0d %s", k, name), mdl, lit);
  endtask

  initial begin
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state and free-running sequence.
    expect_lit(0, "reset pc", pc_o[0], m[0].pc, 32'h0);
    expect_lit(0, "reset epc", epc_o[0], m[0].epc, 32'h0);
    check("u0 reset exl", 32'(exl_o[0]), 32'h0);
    check("u0 reset pending", 32'(pend_o[0]), 32'h0);
    check("u0 reset pcsrc", 32'(pcsrc_o[0]), 32'h0);
    tick(); expect_lit(0, "free pc 4", pc_o[0], m[0].pc, 32'h4);
    tick(); expect_lit(1, "free pc 8", pc_o[1], m[1].pc, 32'h8);
    tick(); expect_lit(0, "free pc 12", pc_o[0], m[0].pc, 32'hC);

    // Conditional branch, no delay slot.
    jr = 1'b1; rs = 32'h40; tick(); idle();
    expect_lit(0, "jr to 0x40", pc_o[0], m[0].pc, 32'h40);
    beq = 1'b1; zerof = 1'b1; imm = 26'h000FFFE; tick(); idle();
    expect_lit(0, "beq taken", pc_o[0], m[0].pc, 32'h3C);
    jr = 1'b1; rs = 32'h40; tick(); idle();
    beq = 1'b1; zerof = 1'b0; imm = 26'h000FFFE; tick(); idle();
    expect_lit(0, "beq not taken", pc_o[0], m[0].pc, 32'h44);

    // Wrap at the top of the address space.
    jr = 1'b1; rs = 32'hFFFF_FFFC; tick(); idle();
    expect_lit(0, "pc top", pc_o[0], m[0].pc, 32'hFFFF_FFFC);
    tick();
    expect_lit(0, "pc wrap", pc_o[0], m[0].pc, 32'h0);

    // Delay slot: jump, then exception in the slot.
    do_reset();
    jr = 1'b1; rs = 32'h100; tick(); idle();
    expect_lit(1, "jr slot pc", pc_o[1], m[1].pc, 32'h4);
    tick();
    expect_lit(1, "jr target", pc_o[1], m[1].pc, 32'h100);
    jump = 1'b1; imm = 26'h40; tick(); idle();
    expect_lit(1, "jump slot pc", pc_o[1], m[1].pc, 32'h104);
    tick();
    expect_lit(1, "jump target", pc_o[1], m[1].pc, 32'h100);
    jump = 1'b1; imm = 26'h40; tick(); idle();
    exception = 1'b1; #1;
    check("u1 slot exc pcsrc", 32'(pcsrc_o[1]), 32'h3);
    tick(); idle();
    expect_lit(1, "slot exc pc", pc_o[1], m[1].pc, EXC_VEC);
    expect_lit(1, "slot exc epc", epc_o[1], m[1].epc, 32'h100);
    check("u1 slot exc bd", 32'(bd_o[1]), 32'h1);
    eret = 1'b1; tick(); idle();
    check("u1 eret exl", 32'(exl_o[1]), 32'h0);

    // Exception entry, no nesting, ERET.
    do_reset();
    jr = 1'b1; rs = 32'h20; tick(); idle();
    exception = 1'b1; tick(); idle();
    expect_lit(0, "exc pc", pc_o[0], m[0].pc, EXC_VEC);
    expect_lit(0, "exc epc", epc_o[0], m[0].epc, 32'h20);
    check("u0 exc exl", 32'(exl_o[0]), 32'h1);
    check("u0 exc bd", 32'(bd_o[0]), 32'h0);
    tick();
    expect_lit(0, "handler pc", pc_o[0], m[0].pc, 32'h184);
    exception = 1'b1; tick(); idle();
    expect_lit(0, "nested epc", epc_o[0], m[0].epc, 32'h20);
    eret = 1'b1; #1;
    check("u0 eret pcsrc", 32'(pcsrc_o[0]), 32'h2);
    tick(); idle();
    expect_lit(0, "eret pc", pc_o[0], m[0].pc, 32'h20);
    check("u0 eret exl", 32'(exl_o[0]), 32'h0);

    // Stall with a latched exception.
    stall = 1'b1; exception = 1'b1; tick(); exception = 1'b0;
    tick(); #1;
    check("u0 stall pcsrc", 32'(pcsrc_o[0]), 32'h0);
    tick();
    expect_lit(0, "stall hold pc", pc_o[0], m[0].pc, 32'h20);
    check("u0 stall pending", 32'(pend_o[0]), 32'h1);
    stall = 1'b0; tick();
    expect_lit(0, "pending taken pc", pc_o[0], m[0].pc, EXC_VEC);
    check("u0 pending cleared", 32'(pend_o[0]), 32'h0);

    // Exception beats ERET; reset discards a stored target.
    exception = 1'b1; eret = 1'b1; #1;
    check("u0 exc+eret pcsrc", 32'(pcsrc_o[0]), 32'h3);
    tick(); idle();
    expect_lit(0, "exc+eret pc", pc_o[0], m[0].pc, EXC_VEC);
    do_reset();
    jump = 1'b1; imm = 26'h40; tick(); idle();
    rst = 1'b1; tick(); rst = 1'b0;
    expect_lit(1, "reset in slot pc", pc_o[1], m[1].pc, RST_VEC);
    tick();
    expect_lit(1, "target discarded", pc_o[1], m[1].pc, 32'h4);

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 199) == 0);
      stall     = ($urandom_range(0, 7) == 0);
      exception = ($urandom_range(0, 19) == 0);
      eret      = ($urandom_range(0, 14) == 0);
      jump      = ($urandom_range(0, 11) == 0);
      jr        = ($urandom_range(0, 14) == 0);
      beq       = ($urandom_range(0, 7) == 0);
      bne       = ($urandom_range(0, 7) == 0);
      zerof     = 1'($urandom);
      imm       = 26'($urandom);
      rs        = $urandom & 32'hFFFF_FFFC;
      tick();
    end
    idle();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
